// File: rtl/vga_pkg.sv
// Shared font ROM constants and the round-robin pointer helper
// used by font_rom_arbiter.
package vga_pkg;

  localparam int FONT_ADDR_W  = 11;
  localparam int FONT_DATA_W  = 8;
  localparam int FONT_ROM_LAT = 1;

  // Next requester index with an explicit wrap from n-1 back to 0.
  function automatic int wrap_next(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/font_rom_arbiter_rr_pick.sv
// rr_pick: combinational round-robin winner search. Scans upward from ptr,
// wrapping at N_REQ-1, and returns a one-hot grant plus the winner index.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [PTR_W-1:0] win_idx
);

  logic [PTR_W:0]   sum_s;
  logic [PTR_W-1:0] idx_s;
  logic             hit_s;
  logic             found_s;

  // First requesting slot at or after ptr; the sum carries one spare bit so the wrap never overflows.
  always_comb begin
    gnt     = '0;
    win_idx = '0;
    found_s = 1'b0;
    sum_s   = '0;
    idx_s   = '0;
    hit_s   = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      sum_s        = {1'b0, ptr} + (PTR_W + 1)'(k);
      sum_s        = (sum_s >= (PTR_W + 1)'(N_REQ)) ? sum_s - (PTR_W + 1)'(N_REQ) : sum_s;
      idx_s        = sum_s[PTR_W-1:0];
      hit_s        = !found_s && req[idx_s];
      gnt[idx_s]   = gnt[idx_s] | hit_s;
      win_idx      = hit_s ? idx_s : win_idx;
      found_s      = found_s | hit_s;
    end
  end

endmodule

// File: rtl/font_rom_arbiter.sv
// font_rom_arbiter: shares one external font ROM among N_REQ text requesters,
// fully pipelined with a one-hot owner tag per read. Macro FONT_ARB_PRIO0_EN
// gives requester 0 fixed priority over the round-robin.
module font_rom_arbiter
  import vga_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int ROM_LAT = FONT_ROM_LAT
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [N_REQ-1:0]                   req,
  input  logic [N_REQ-1:0][FONT_ADDR_W-1:0]  addr,
  output logic [N_REQ-1:0]                   gnt,
  output logic [FONT_ADDR_W-1:0]             rom_addr,
  input  logic [FONT_DATA_W-1:0]             rom_data,
  output logic [FONT_DATA_W-1:0]             rdata,
  output logic [N_REQ-1:0]                   rvalid,
  output logic                               busy
);

  localparam int PTR_W = $clog2(N_REQ);

  logic [PTR_W-1:0]       ptr_r;
  logic [PTR_W-1:0]       rr_idx_s;
  logic [PTR_W-1:0]       pick_idx_s;
  logic [N_REQ-1:0]       rr_gnt_s;
  logic [N_REQ-1:0]       pick_gnt_s;
  logic [N_REQ-1:0]       gnt_s;
  logic                   prio_win_s;
  logic                   xfer_s;
  logic [N_REQ-1:0]       tag_r [ROM_LAT];
  logic [N_REQ-1:0]       rvalid_r;
  logic [FONT_ADDR_W-1:0] rom_addr_r;
  logic [FONT_DATA_W-1:0] rdata_r;
  logic                   busy_s;

  rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .req     (req),
    .ptr     (ptr_r),
    .gnt     (rr_gnt_s),
    .win_idx (rr_idx_s)
  );

  // Winner selection: round-robin, optionally overridden by requester 0.
  always_comb begin
    pick_gnt_s = rr_gnt_s;
    pick_idx_s = rr_idx_s;
    prio_win_s = 1'b0;
`ifdef FONT_ARB_PRIO0_EN
    if (req[0]) begin
      pick_gnt_s = {{(N_REQ - 1){1'b0}}, 1'b1};
      pick_idx_s = '0;
      prio_win_s = 1'b1;
    end else begin
      pick_gnt_s = rr_gnt_s;
      pick_idx_s = rr_idx_s;
      prio_win_s = 1'b0;
    end
`endif
  end

  // Grants are only ever raised for requesting slots, so any grant bit is a transfer.
  assign gnt_s  = rst ? '0 : (pick_gnt_s & req);
  assign xfer_s = |gnt_s;

  // Pointer and ROM address update on each transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r      <= '0;
      rom_addr_r <= '0;
    end else if (xfer_s) begin
      rom_addr_r <= addr[pick_idx_s];
      ptr_r      <= prio_win_s ? ptr_r : PTR_W'(wrap_next(int'(pick_idx_s), N_REQ));
    end
  end

  // Owner tags travel alongside the ROM latency; rdata is captured as the tag exits.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ROM_LAT; i++) begin
        tag_r[i] <= '0;
      end
      rvalid_r <= '0;
      rdata_r  <= '0;
    end else begin
      tag_r[0] <= gnt_s;
      for (int i = 1; i < ROM_LAT; i++) begin
        tag_r[i] <= tag_r[i-1];
      end
      rvalid_r <= tag_r[ROM_LAT-1];
      if (|tag_r[ROM_LAT-1]) begin
        rdata_r <= rom_data;
      end
    end
  end

  // Busy while any tag stage or the return stage holds an owner.
  always_comb begin
    busy_s = |rvalid_r;
    for (int i = 0; i < ROM_LAT; i++) begin
      busy_s = busy_s | (|tag_r[i]);
    end
  end

  assign gnt      = gnt_s;
  assign rom_addr = rom_addr_r;
  assign rdata    = rdata_r;
  assign rvalid   = rvalid_r;
  assign busy     = busy_s;

endmodule
